// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I format codes, field widths and opcode constants
package rv_isa_pkg;

  localparam int XLEN     = 32;
  localparam int FMT_W    = 3;
  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;
  localparam int FUNC3_W  = 3;
  localparam int FUNC7_W  = 7;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - combinational packing of decoded fields into an RV32I word
module instr_packer
  import rv_isa_pkg::*;
(
  input  logic [FMT_W-1:0]    fmt_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [REG_W-1:0]    rd_i,
  input  logic [FUNC3_W-1:0]  func3_i,
  input  logic [REG_W-1:0]    rs1_i,
  input  logic [REG_W-1:0]    rs2_i,
  input  logic [FUNC7_W-1:0]  func7_i,
  input  logic [XLEN-1:0]     imm_i,
  output logic [XLEN-1:0]     word_o,
  output logic                illegal_o
);

  // Only the two low opcode bits are checked: every 32-bit RV32I opcode ends in 2'b11.
  always_comb begin
    word_o    = '0;
    illegal_o = (opcode_i[1:0] != 2'b11);
    case (fmt_i)
      FMT_R: word_o = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      word_o = '0;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - handshaked RV32I encoder with program address counter
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FMT_W-1:0]    fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [FUNC3_W-1:0]  func3,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [FUNC7_W-1:0]  func7,
  input  logic [XLEN-1:0]     imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     instruction,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                full,
  output logic                err_illegal
);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   packed_word;
  logic              packed_illegal;
  logic              accept;
  logic              out_hs;

  instr_packer u_packer (
    .fmt_i     (fmt),
    .opcode_i  (opcode),
    .rd_i      (rd),
    .func3_i   (func3),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .func7_i   (func7),
    .imm_i     (imm),
    .word_o    (packed_word),
    .illegal_o (packed_illegal)
  );

  assign in_ready = !clear && !full_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // The counter names the word currently presented, so it advances only on output handshakes.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    full_d      = full_q;
    err_d       = err_q;
    if (clear) begin
      out_valid_d = 1'b0;
      addr_d      = '0;
      full_d      = 1'b0;
      err_d       = 1'b0;
    end else begin
      if (out_hs) begin
        out_valid_d = 1'b0;
        addr_d      = addr_q + ADDR_W'(1);
        if (addr_q == '1) begin
          full_d = 1'b1;
        end
      end
      if (accept) begin
        if (packed_illegal) begin
          err_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          instr_d     = packed_word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign instruction = instr_q;
  assign out_addr    = addr_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder against a reference model
module tb_instr_encoder;
  import rv_isa_pkg::*;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [2:0]    func3;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [6:0]    func7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instruction;
  logic [AW-1:0] out_addr;
  logic          full;
  logic          err_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          m_addr;
  logic        m_full;
  logic        m_err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fmt         (fmt),
    .opcode      (opcode),
    .rd          (rd),
    .func3       (func3),
    .rs1         (rs1),
    .rs2         (rs2),
    .func7       (func7),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .out_addr    (out_addr),
    .full        (full),
    .err_illegal (err_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bit positions written out as shifts and modulo, straight from the ISA field tables.
  function automatic logic [32:0] ref_encode(input int f, input logic [6:0] op,
      input logic [4:0] rd_v, input logic [2:0] f3, input logic [4:0] r1,
      input logic [4:0] r2, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] mid;
    if (f >= 6 || (op % 4) != 3) return {1'b1, 32'h0};
    mid = (32'(r1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      0: w = (32'(f7) << 25) | (32'(r2) << 20) | mid | (32'(rd_v) << 7);
      1: w = ((im % 4096) << 20) | mid | (32'(rd_v) << 7);
      2: w = (((im >> 5) % 128) << 25) | (32'(r2) << 20) | mid | ((im % 32) << 7);
      3: w = (((im >> 12) % 2) << 31) | (((im >> 5) % 64) << 25) | (32'(r2) << 20) | mid
           | (((im >> 1) % 16) << 8) | (((im >> 11) % 2) << 7);
      4: w = (im & 32'hFFFF_F000) | (32'(rd_v) << 7) | 32'(op);
      default: w = (((im >> 20) % 2) << 31) | (((im >> 1) % 1024) << 21)
                 | (((im >> 11) % 2) << 20) | (((im >> 12) % 256) << 12)
                 | (32'(rd_v) << 7) | 32'(op);
    endcase
    return {1'b0, w};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr = 0;
    m_full = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic set_tuple(input int f, input logic [6:0] op, input logic [4:0] rd_v,
      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
      input logic [6:0] f7, input logic [31:0] im);
    fmt = 3'(f); opcode = op; rd = rd_v; func3 = f3;
    rs1 = r1; rs2 = r2; func7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic set_random_tuple();
    logic [6:0] op;
    op = 7'($urandom);
    if ($urandom_range(0, 7) != 0) op[1:0] = 2'b11;
    set_tuple($urandom_range(0, 7), op, 5'($urandom), 3'($urandom), 5'($urandom),
              5'($urandom), 7'($urandom), $urandom);
  endtask

  // Entered on a falling edge with inputs set; checks, updates the model, returns on the next falling edge.
  task automatic tick();
    logic        exp_ready;
    logic [32:0] e;
    #1;
    exp_ready = !clear && !m_full && (exp_q.size() == 0 || out_ready);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("full", full, m_full);
    chk("err_illegal", err_illegal, m_err);
    if (exp_q.size() != 0) begin
      chk("instruction", instruction, exp_q[0]);
      chk("out_addr", out_addr, m_addr);
    end
    if (clear) begin
      model_reset();
    end else begin
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        m_addr++;
        if (m_addr == CAP) begin
          m_addr = 0;
          m_full = 1'b1;
        end
      end
      if (in_valid && exp_ready) begin
        e = ref_encode(int'(fmt), opcode, rd, func3, rs1, rs2, func7, imm);
        if (e[32]) m_err = 1'b1;
        else exp_q.push_back(e[31:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_tuple(0, 7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 32'h0);
    in_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_full", full, 1'b0);
    chk("rst_err", err_illegal, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // R-type, one cycle latency
    set_tuple(FMT_R, OP_REG, 5'd10, 3'd0, 5'd6, 5'd19, 7'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("r_word", instruction, 32'h0133_0533);
    chk("r_addr", out_addr, 0);
    out_ready = 1'b1;
    tick();

    // I/S/B back-to-back
    pulse_clear();
    set_tuple(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    chk("addi_word", instruction, 32'h0050_0093);
    chk("addi_addr", out_addr, 0);
    set_tuple(FMT_S, OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    tick();
    chk("sw_word", instruction, 32'h0020_A423);
    chk("sw_addr", out_addr, 1);
    set_tuple(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
    tick();
    chk("beq_word", instruction, 32'h0020_8463);
    chk("beq_addr", out_addr, 2);
    in_valid = 1'b0;
    tick();

    // U/J
    pulse_clear();
    set_tuple(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    tick();
    chk("lui_word", instruction, 32'h1234_52B7);
    set_tuple(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd16);
    tick();
    chk("jal_word", instruction, 32'h0100_00EF);
    chk("jal_addr", out_addr, 1);
    in_valid = 1'b0;
    tick();

    // Backpressure
    pulse_clear();
    set_tuple(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    set_tuple(FMT_S, OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_word", instruction, 32'h0050_0093);
      chk("stall_addr", out_addr, 0);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_word", instruction, 32'h0020_A423);
    chk("release_addr", out_addr, 1);
    in_valid = 1'b0;
    tick();

    // Illegal tuples and clear
    pulse_clear();
    set_tuple(6, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    set_tuple(FMT_R, 7'b0110000, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("illegal_err", err_illegal, 1'b1);
    chk("illegal_no_out", out_valid, 1'b0);
    set_tuple(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    chk("illegal_addr_kept", out_addr, 0);
    in_valid = 1'b0;
    tick();
    pulse_clear();
    chk("clear_err", err_illegal, 1'b0);

    // Capacity
    for (int i = 0; i < CAP; i++) begin
      set_random_tuple();
      fmt = 3'($urandom_range(0, 5));
      opcode[1:0] = 2'b11;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("cap_full", full, 1'b1);
    set_random_tuple();
    tick();
    chk("cap_stall", in_ready, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cap_cleared", full, 1'b0);
    set_tuple(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    tick();
    chk("cap_wrap_addr", out_addr, 0);
    in_valid = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) set_random_tuple();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 15) == 0);
      tick();
    end
    clear = 1'b0;

    // Reset mid-stream
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_tuple(FMT_I, OP_IMM, 5'($urandom), 3'($urandom), 5'($urandom), 5'd0, 7'd0, $urandom);
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_addr", out_addr, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      set_random_tuple();
      out_ready = ($urandom_range(0, 1) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
